// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - states, opcodes and select encodings for the multicycle controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic       reg_write;
    } ctrl_word_t;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            OP_JAL:    imm_sel = IMM_J;
            default:   imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// rtl/ctrl_outdec.sv - Moore control word decoded from state and opcode
module ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [6:0] op_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        cw_o         = '0;
        cw_o.imm_src = imm_sel(op_i);
        case (state_i)
            FETCH: begin
                cw_o.mem_req    = 1'b1;
                cw_o.alu_src_a  = SRCA_PC;
                cw_o.alu_src_b  = SRCB_FOUR;
                cw_o.alu_op     = ALU_ADD;
                cw_o.result_src = RES_ALURESULT;
            end
            DECODE: begin
                cw_o.alu_src_a = SRCA_OLDPC;
                cw_o.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                cw_o.alu_src_a = SRCA_REGA;
                cw_o.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                cw_o.mem_req    = 1'b1;
                cw_o.adr_src    = 1'b1;
                cw_o.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                cw_o.result_src = RES_DATA;
                cw_o.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                cw_o.mem_req   = 1'b1;
                cw_o.mem_write = 1'b1;
                cw_o.adr_src   = 1'b1;
            end
            EXECR: begin
                cw_o.alu_src_a = SRCA_REGA;
                cw_o.alu_src_b = SRCB_REGB;
                cw_o.alu_op    = ALU_FUNCT;
            end
            EXECI: begin
                cw_o.alu_src_a = SRCA_REGA;
                cw_o.alu_src_b = SRCB_IMM;
                cw_o.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                cw_o.result_src = RES_ALUOUT;
                cw_o.reg_write  = 1'b1;
            end
            BRANCH: begin
                cw_o.alu_src_a = SRCA_REGA;
                cw_o.alu_src_b = SRCB_REGB;
                cw_o.alu_op    = ALU_SUB;
            end
            JAL: begin
                cw_o.alu_src_a = SRCA_OLDPC;
                cw_o.alu_src_b = SRCB_FOUR;
            end
            default: cw_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM; PERF_CNT_EN adds cycle/instret counters
module multicycle_ctrl
    import ctrl_pkg::*;
`ifdef PERF_CNT_EN
#(
    parameter int CNT_WIDTH = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       funct3_0,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic       RegWrite,
    output logic       Illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] CycleCnt,
    output logic [CNT_WIDTH-1:0] InstretCnt
`endif
);

    state_t     state_q, state_d;
    ctrl_word_t cw;
    logic       illegal_d;
    logic       ir_write_d;
    logic       pc_write_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:    if (MemReady) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (MemReady) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (MemReady) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Mealy strobes: fetch completion and branch-taken react in the same cycle
    assign ir_write_d = (state_q == FETCH) && MemReady;
    assign pc_write_d = ir_write_d
                      || ((state_q == BRANCH) && (Zero ^ funct3_0))
                      || (state_q == JAL);

    ctrl_outdec u_outdec (
        .state_i (state_q),
        .op_i    (op),
        .cw_o    (cw)
    );

    // Reset must kill every strobe immediately, including an in-flight store
    assign MemReq    = rst ? 1'b0 : cw.mem_req;
    assign MemWrite  = rst ? 1'b0 : cw.mem_write;
    assign IRWrite   = rst ? 1'b0 : ir_write_d;
    assign PCWrite   = rst ? 1'b0 : pc_write_d;
    assign AdrSrc    = rst ? 1'b0 : cw.adr_src;
    assign ALUSrcA   = rst ? 2'b00 : cw.alu_src_a;
    assign ALUSrcB   = rst ? 2'b00 : cw.alu_src_b;
    assign ALUop     = rst ? 2'b00 : cw.alu_op;
    assign ImmSrc    = rst ? 2'b00 : cw.imm_src;
    assign ResultSrc = rst ? 2'b00 : cw.result_src;
    assign RegWrite  = rst ? 1'b0 : cw.reg_write;
    assign Illegal   = rst ? 1'b0 : illegal_d;

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_q, instret_cnt_q;
    logic                 retire;

    assign retire = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWRITE, ALUWB, BRANCH});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
            if (retire) instret_cnt_q <= instret_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign CycleCnt   = cycle_cnt_q;
    assign InstretCnt = instret_cnt_q;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that sequences the shared RV32I datapath: one ALU, one unified instruction/data memory port and one register file used over several cycles per instruction. It sits beside the datapath, takes the latched opcode, funct3[0] and ALU Zero flag, and drives all datapath selects and enables. A ready/request handshake on the memory port stretches fetch and data-access states.

## Interface
- CNT_WIDTH, 32, width of the performance counters (only with PERF_CNT_EN)
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  opcode from the instruction register
- funct3_0  in  1  funct3[0]: 0 = beq, 1 = bne
- Zero  in  1  ALU result-zero flag
- MemReady  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access requested
- MemWrite  out  1  store strobe, valid only with MemReq
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC
- AdrSrc  out  1  0 = PC, 1 = Result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RegA
- ALUSrcB  out  2  00 RegB, 01 ImmExt, 10 constant 4
- ALUop  out  2  00 add, 01 subtract, 10 funct-decoded
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded from op in every state
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- RegWrite  out  1  register-file write enable
- Illegal  out  1  one-cycle pulse on an unsupported opcode
- CycleCnt, InstretCnt  out  CNT_WIDTH  performance counters (PERF_CNT_EN only)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUop=00, ResultSrc=10. Stay until MemReady; in the MemReady cycle IRWrite=1, PCWrite=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUop=00 (precompute the branch/jump target). Dispatch on op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> FETCH with Illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUop=00. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Wait for MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Wait for MemReady, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUop=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUop=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUop=01, ResultSrc=00. PCWrite = Zero XOR funct3_0. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUop=00, ResultSrc=00, PCWrite=1, then ALUWB (rd receives PC+4).
- Any output not listed for a state is 0. Selects that are don't-care are driven 0.

## Timing
- State register updates on the clk rising edge.
- Select outputs are Moore (functions of state only).
- PCWrite in FETCH and BRANCH, and IRWrite, are Mealy: they are combinational in MemReady, Zero and funct3_0.
- Latency with MemReady tied high: R/I-type 4 cycles, lw 5, sw 4, branch 3, jal 4, illegal 2.
- Each cycle MemReady is low in a memory state adds one cycle. A MemReady pulse outside a memory state is ignored.
- rst asserted: state goes to FETCH immediately. While rst is high, every output is forced to 0, including MemReq and MemWrite.
- Reset in the middle of an instruction abandons it with no partial register or memory write. After release, the first edge begins a fresh FETCH.

## Configuration
- PERF_CNT_EN defined:
  - CycleCnt increments every cycle rst is low.
  - InstretCnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH; illegal dispatches do not count.
  - Both counters reset to 0 and wrap modulo 2^CNT_WIDTH.
- PERF_CNT_EN undefined: the counters and their ports do not exist. All other behaviour is identical.

## Structure
- Package ctrl_pkg holds:
  - the state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - encoding constants for ALUSrcA, ALUSrcB, ALUop, ResultSrc and ImmSrc
- One sub-module, ctrl_outdec: purely combinational map from state and op to the Moore control word. The top level holds the state register, next-state logic, the Mealy PCWrite/IRWrite terms and the counters.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 at once; after release, state is FETCH and MemReq=1 on the next cycle.
- add (op 0110011), MemReady=1 -> exactly 4 cycles; RegWrite=1 only in ALUWB with ResultSrc=00; IRWrite and PCWrite each pulse once in FETCH.
- lw with MemReady low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total; MEMWB has ResultSrc=01 and RegWrite=1.
- Branch: beq (funct3_0=0) with Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0. bne (funct3_0=1) with Zero=0 -> PCWrite=1.
- op=0110111 -> one-cycle Illegal pulse at DECODE, back to FETCH, no RegWrite or MemWrite; InstretCnt unchanged.
- sw with rst asserted during MEMWRITE while MemReady=0 -> MemWrite drops to 0 that cycle, and no store completes.
- PERF_CNT_EN: run 3 back-to-back add instructions -> InstretCnt=3 and CycleCnt=12.
- PERF_CNT_EN with CNT_WIDTH=4: run 16 cycles -> CycleCnt wraps to 0.
